// File: rtl/cella_array_ctrl_if.sv
// Command / response handshake bundle between a requester and the CELLA
// array sequencer. The requester side is "master", the sequencer is "slave".
interface cella_array_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cella_array_ctrl.sv
// Operation sequencer feeding the CELLA row decoder. Runs each accepted
// command through precharge then evaluation, captures the sense-amp result
// at the end of evaluation and hands it back over the response handshake.
// Every decoder-facing output and the response are driven straight from flops.
module cella_array_ctrl #(
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cella_array_ctrl_if.slave  bus,
  input  logic [3:0]         sa_out,
  output logic               cs,
  output logic               w_en,
  output logic               MAC_en,
  output logic               read_bar,
  output logic [1:0]         addr,
  output logic [3:0]         data,
  output logic               preb_en,
  output logic               busy
);

  localparam int CNT_MAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_EVAL,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_SEARCH  = 2'b01,
    OP_MAC     = 2'b10,
    OP_MAC_BAR = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic             w_en_q, w_en_d;
  logic             mac_en_q, mac_en_d;
  logic             read_bar_q, read_bar_d;
  logic [1:0]       addr_q, addr_d;
  logic [3:0]       data_q, data_d;
  logic             preb_en_q, preb_en_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_data_q, rsp_data_d;

  // Next-state and next-output logic; every flop holds unless a phase changes it.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    w_en_d      = w_en_q;
    mac_en_d    = mac_en_q;
    read_bar_d  = read_bar_q;
    addr_d      = addr_q;
    data_d      = data_q;
    preb_en_d   = preb_en_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = op_e'(bus.cmd_op);
          addr_d      = bus.cmd_addr;
          data_d      = bus.cmd_data;
          cs_d        = 1'b1;
          w_en_d      = (op_e'(bus.cmd_op) == OP_WRITE);
          mac_en_d    = (op_e'(bus.cmd_op) == OP_MAC) || (op_e'(bus.cmd_op) == OP_MAC_BAR);
          read_bar_d  = (op_e'(bus.cmd_op) == OP_MAC_BAR);
          preb_en_d   = 1'b0;
          cnt_d       = CNT_W'(PRE_CYCLES - 1);
          cmd_ready_d = 1'b0;
          state_d     = S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_W'(EVAL_CYCLES - 1);
          preb_en_d = 1'b1;
          state_d   = S_EVAL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EVAL: begin
        if (cnt_q == '0) begin
          rsp_data_d  = (op_q == OP_WRITE) ? 4'b0000 : sa_out;
          rsp_valid_d = 1'b1;
          cs_d        = 1'b0;
          preb_en_d   = 1'b0;
          w_en_d      = 1'b0;
          mac_en_d    = 1'b0;
          read_bar_d  = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WRITE;
      cnt_q       <= '0;
      cs_q        <= 1'b0;
      w_en_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      read_bar_q  <= 1'b0;
      addr_q      <= 2'b00;
      data_q      <= 4'b0000;
      preb_en_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'b0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      w_en_q      <= w_en_d;
      mac_en_q    <= mac_en_d;
      read_bar_q  <= read_bar_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      preb_en_q   <= preb_en_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cs            = cs_q;
  assign w_en          = w_en_q;
  assign MAC_en        = mac_en_q;
  assign read_bar      = read_bar_q;
  assign addr          = addr_q;
  assign data          = data_q;
  assign preb_en       = preb_en_q;
  assign busy          = (state_q != S_IDLE);
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cella_array_ctrl.sv
// Self-checking bench for cella_array_ctrl: a default-parameter instance plus
// a PRE=2 / EVAL=3 instance, checked against a cycle timeline derived from
// the command rules (precharge, evaluation, response) rather than the FSM.
module tb_cella_array_ctrl;

  localparam int PRE  = 1;
  localparam int EVAL = 2;
  localparam int LAT  = PRE + EVAL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sa_out, sa_out2;
  logic       cs, w_en, mac_en, read_bar, preb_en, busy;
  logic       cs2, w_en2, mac_en2, read_bar2, preb_en2, busy2;
  logic [1:0] addr, addr2;
  logic [3:0] data, data2;

  int errors = 0;
  int checks = 0;

  cella_array_ctrl_if bus ();
  cella_array_ctrl_if bus2 ();

  cella_array_ctrl #(.PRE_CYCLES(PRE), .EVAL_CYCLES(EVAL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sa_out(sa_out),
    .cs(cs), .w_en(w_en), .MAC_en(mac_en), .read_bar(read_bar),
    .addr(addr), .data(data), .preb_en(preb_en), .busy(busy)
  );

  cella_array_ctrl #(.PRE_CYCLES(2), .EVAL_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .sa_out(sa_out2),
    .cs(cs2), .w_en(w_en2), .MAC_en(mac_en2), .read_bar(read_bar2),
    .addr(addr2), .data(data2), .preb_en(preb_en2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one command when the DUT is ready; returns at cycle 0 of PRE.
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_cmd_timeout: cmd_ready=%b want 1", bus.cmd_ready);
    end
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 2'b00; bus.cmd_data = 4'h0;
    bus.rsp_ready = 1'b1; sa_out = 4'h0;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = 2'b00; bus2.cmd_addr = 2'b00; bus2.cmd_data = 4'h0;
    bus2.rsp_ready = 1'b1; sa_out2 = 4'h0;
    #3;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, cs, w_en, mac_en, read_bar, addr, data, preb_en, busy} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0",
               {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, cs, w_en, mac_en, read_bar, addr, data, preb_en, busy});
    end
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: cmd_ready=%b want 0", bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_after_release: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, busy);
    end
    // Assert reset in the middle of evaluation of a SEARCH.
    sa_out = 4'h9;
    send_cmd(2'b01, 2'b11, 4'h5);
    tick();
    checks++;
    if (preb_en !== 1'b1 || cs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL eval_before_reset: preb_en=%b cs=%b want 1 1", preb_en, cs);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({preb_en, cs, bus.rsp_valid, bus.cmd_ready, busy, data, addr} !== 11'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h want 0", {preb_en, cs, bus.rsp_valid, bus.cmd_ready, busy, data, addr});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_mid_reset: cmd_ready=%b want 1", bus.cmd_ready);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (bus.rsp_valid !== 1'b0 || cs !== 1'b0) seen++;
        tick();
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("[TB] FAIL no_partial_response: active cycles=%0d want 0", seen);
      end
    end
  endtask

  task automatic test_write;
    bus.rsp_ready = 1'b1;
    sa_out = 4'hF;
    send_cmd(2'b00, 2'b10, 4'b1011);
    for (int k = 0; k < LAT; k++) begin
      checks++;
      if ({cs, w_en, mac_en, read_bar, addr, data, preb_en, bus.rsp_valid} !== {4'b1100, 2'b10, 4'b1011, (k >= PRE), 1'b0}) begin
        errors++;
        $display("[TB] FAIL write_cycle%0d: got %h want %h", k,
                 {cs, w_en, mac_en, read_bar, addr, data, preb_en, bus.rsp_valid},
                 {4'b1100, 2'b10, 4'b1011, (k >= PRE), 1'b0});
      end
      tick();
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, cs, w_en, preb_en, bus.cmd_ready} !== {1'b1, 4'b0000, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL write_response: valid/data/cs/w_en/preb/ready=%b want 1_0000_0000",
               {bus.rsp_valid, bus.rsp_data, cs, w_en, preb_en, bus.cmd_ready});
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_one_cycle_rsp: rsp_valid=%b cmd_ready=%b want 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_search;
    bus.rsp_ready = 1'b1;
    sa_out = 4'hF;
    send_cmd(2'b01, 2'b00, 4'b0110);
    for (int k = 0; k < LAT; k++) begin
      sa_out = (k >= PRE) ? 4'b0100 : 4'hF;
      checks++;
      if ({w_en, mac_en, read_bar, data, cs} !== {3'b000, 4'b0110, 1'b1}) begin
        errors++;
        $display("[TB] FAIL search_cycle%0d: got %b want 0000110_1", k, {w_en, mac_en, read_bar, data, cs});
      end
      tick();
    end
    sa_out = 4'hF;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL search_result: valid=%b data=%b want 1 0100", bus.rsp_valid, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_mac;
    bus.rsp_ready = 1'b1;
    send_cmd(2'b11, 2'b01, 4'h3);
    for (int k = 0; k < LAT; k++) begin
      sa_out = 4'hC;
      checks++;
      if ({mac_en, read_bar, w_en, addr} !== {3'b110, 2'b01}) begin
        errors++;
        $display("[TB] FAIL mac_bar_cycle%0d: got %b want 11001", k, {mac_en, read_bar, w_en, addr});
      end
      tick();
    end
    checks++;
    if (bus.rsp_data !== 4'hC || {mac_en, read_bar} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mac_bar_result: data=%h ctrl=%b want c 00", bus.rsp_data, {mac_en, read_bar});
    end
    tick();
    // MAC on the PRE=2 / EVAL=3 instance: response five cycles after acceptance.
    bus2.rsp_ready = 1'b1;
    bus2.cmd_op = 2'b10; bus2.cmd_addr = 2'b11; bus2.cmd_data = 4'h5; bus2.cmd_valid = 1'b1;
    checks++;
    if (bus2.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mac_long_ready: cmd_ready=%b want 1", bus2.cmd_ready);
    end
    tick();
    bus2.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sa_out2 = (k == 4) ? 4'hA : 4'h3;
      checks++;
      if ({cs2, mac_en2, read_bar2, preb_en2, bus2.rsp_valid} !== {3'b110, (k >= 2), 1'b0}) begin
        errors++;
        $display("[TB] FAIL mac_long_cycle%0d: got %b want %b", k,
                 {cs2, mac_en2, read_bar2, preb_en2, bus2.rsp_valid}, {3'b110, (k >= 2), 1'b0});
      end
      tick();
    end
    checks++;
    if (bus2.rsp_valid !== 1'b1 || bus2.rsp_data !== 4'hA || cs2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mac_long_result: valid=%b data=%h cs=%b want 1 a 0", bus2.rsp_valid, bus2.rsp_data, cs2);
    end
    tick();
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    send_cmd(2'b01, 2'b00, 4'h3);
    bus.cmd_op = 2'b00; bus.cmd_addr = 2'b01; bus.cmd_data = 4'hC; bus.cmd_valid = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      sa_out = (k == LAT - 1) ? 4'h5 : 4'h0;
      tick();
    end
    sa_out = 4'hE;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.cmd_ready, cs, preb_en, busy} !== {1'b1, 4'h5, 4'b0001}) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d: valid/data/ready/cs/preb/busy=%b want 1_0101_0001", i,
                 {bus.rsp_valid, bus.rsp_data, bus.cmd_ready, cs, preb_en, busy});
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, cs, busy} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL after_handshake: valid/ready/cs/busy=%b want 0100", {bus.rsp_valid, bus.cmd_ready, cs, busy});
    end
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({cs, w_en, addr, data, bus.cmd_ready} !== {2'b11, 2'b01, 4'hC, 1'b0}) begin
      errors++;
      $display("[TB] FAIL second_accept: got %b want 11_01_1100_0", {cs, w_en, addr, data, bus.cmd_ready});
    end
    for (int k = 0; k < LAT; k++) tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'h0) begin
      errors++;
      $display("[TB] FAIL second_result: valid=%b data=%h want 1 0", bus.rsp_valid, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_input_hold;
    bus.rsp_ready = 1'b1;
    send_cmd(2'b10, 2'b11, 4'h9);
    bus.cmd_op = 2'b00; bus.cmd_addr = 2'b00; bus.cmd_data = 4'h0;
    for (int k = 0; k < LAT; k++) begin
      sa_out = 4'h7;
      checks++;
      if ({addr, data, mac_en, w_en, read_bar} !== {2'b11, 4'h9, 3'b100}) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got %b want 11_1001_100", k, {addr, data, mac_en, w_en, read_bar});
      end
      tick();
    end
    checks++;
    if (bus.rsp_data !== 4'h7) begin
      errors++;
      $display("[TB] FAIL hold_result: data=%h want 7", bus.rsp_data);
    end
    tick();
  endtask

  // Random commands checked against the precharge/evaluate/response timeline.
  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      logic [1:0] op, a;
      logic [3:0] d, exp_rsp;
      logic [12:0] exp_vec;
      int stall;
      op = 2'($urandom); a = 2'($urandom); d = 4'($urandom);
      stall = $urandom_range(0, 3);
      exp_rsp = 4'h0;
      bus.rsp_ready = 1'b0;
      send_cmd(op, a, d);
      bus.cmd_op = 2'($urandom); bus.cmd_addr = 2'($urandom); bus.cmd_data = 4'($urandom);
      for (int k = 0; k < LAT; k++) begin
        sa_out = 4'($urandom);
        if (k == LAT - 1) exp_rsp = (op == 2'b00) ? 4'h0 : sa_out;
        exp_vec = {1'b1, (op == 2'b00), op[1], (op == 2'b11), (k >= PRE), a, d, 1'b1, 1'b0};
        checks++;
        if ({cs, w_en, mac_en, read_bar, preb_en, addr, data, busy, bus.rsp_valid} !== exp_vec) begin
          errors++;
          $display("[TB] FAIL rand%0d_cycle%0d: got %h want %h", n, k,
                   {cs, w_en, mac_en, read_bar, preb_en, addr, data, busy, bus.rsp_valid}, exp_vec);
        end
        tick();
      end
      sa_out = 4'($urandom);
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, cs, preb_en, bus.cmd_ready} !== {1'b1, exp_rsp, 3'b000}) begin
          errors++;
          $display("[TB] FAIL rand%0d_rsp%0d: got %b want %b", n, s,
                   {bus.rsp_valid, bus.rsp_data, cs, preb_en, bus.cmd_ready}, {1'b1, exp_rsp, 3'b000});
        end
        if (s == stall) bus.rsp_ready = 1'b1;
        tick();
      end
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin
        errors++;
        $display("[TB] FAIL rand%0d_idle: valid/ready/busy=%b want 010", n, {bus.rsp_valid, bus.cmd_ready, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_search();
    test_mac();
    test_backpressure();
    test_input_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cella_array_ctrl.md
# cella_array_ctrl

Operation sequencer that sits directly upstream of the row decoder in the CELLA CAM/MAC macro. It accepts one array command at a time over a valid/ready interface and drives the decoder's control lines through a fixed precharge → evaluate sequence: cs, w_en, MAC_en, read_bar, addr, data and preb_en. At the end of evaluation it captures the 4-bit sense-amp/match-line result and returns it on a valid/ready response port.

## Interface
- PRE_CYCLES, 1, number of precharge cycles (preb_en low, cs high); legal range ≥1.
- EVAL_CYCLES, 2, number of evaluation cycles (preb_en high, word lines live); legal range ≥1.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  operation: 00 WRITE, 01 SEARCH (CAM), 10 MAC, 11 MAC_BAR (MAC with read_bar).
- cmd_addr  in  2  row address.
- cmd_data  in  4  search key or write data.
- sa_out  in  4  sense-amp / match-line outputs from the array.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  4  captured result.
- cs, w_en, MAC_en, read_bar  out  1 each  decoder controls.
- addr  out  2  decoder address.
- data  out  4  decoder data / search key.
- preb_en  out  1  word-line gate; high only during evaluation.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, PRE, EVAL, RESP. There is a single down-counter, sized for max(PRE_CYCLES, EVAL_CYCLES).
- IDLE:
  - cmd_ready=1 and busy=0.
  - cs, preb_en, w_en, MAC_en and read_bar are all 0.
  - On cmd_valid & cmd_ready:
    - latch op, addr and data;
    - drive cs=1;
    - derive the decoder controls from op: WRITE→w_en=1; SEARCH→w_en=0, MAC_en=0; MAC→MAC_en=1, read_bar=0; MAC_BAR→MAC_en=1, read_bar=1;
    - set addr/data outputs from the latched command;
    - load counter=PRE_CYCLES-1 and go to PRE.
- PRE: preb_en=0; all controls held. When counter==0, load EVAL_CYCLES-1 and go to EVAL; otherwise decrement.
- EVAL: preb_en=1; all controls held. When counter==0:
  - register rsp_data ← sa_out, or 4'b0000 for WRITE;
  - drive cs=0, preb_en=0, w_en=MAC_en=read_bar=0;
  - go to RESP.
  - Otherwise decrement.
- RESP:
  - rsp_valid=1 and cmd_ready=0.
  - rsp_data is held stable until the handshake.
  - On rsp_ready, go to IDLE.
- All decoder-facing outputs and rsp_data/rsp_valid are registered, so they are glitch-free.
- addr/data keep their last values outside a command.
- cmd_op/addr/data changing after acceptance has no effect.
- Reset (asynchronous, at any point, including mid-EVAL):
  - state goes to IDLE;
  - every output goes to 0, including cmd_ready (which is 0 while rst_n is low);
  - counter goes to 0.
  - cmd_ready rises in the first cycle after rst_n deasserts. No partial response is ever emitted.

## Timing
- Command accepted at edge T.
- PRE occupies cycles [T, T+PRE_CYCLES). The decoder samples cs=1 at T+1, so its word-line registers are valid before preb_en rises.
- EVAL occupies [T+PRE_CYCLES, T+PRE_CYCLES+EVAL_CYCLES). preb_en is high for exactly EVAL_CYCLES cycles.
- sa_out is sampled at edge T+PRE_CYCLES+EVAL_CYCLES, and rsp_valid rises at that same edge. With the defaults this is T+3.
- If rsp_ready is already high, rsp_valid lasts one cycle. The next cmd_ready=1 follows one cycle later; there is no IDLE bypass.
- Throughput: one command every PRE_CYCLES+EVAL_CYCLES+2 cycles with no backpressure.
- rsp_ready low stalls in RESP indefinitely. Decoder controls stay idle during the stall and no new command is accepted.

## Test plan
- Reset: assert rst_n=0 mid-EVAL of a SEARCH → preb_en, cs and rsp_valid are 0 immediately (asynchronously). After release, cmd_ready=1 one cycle later and no rsp_valid appears.
- WRITE addr=2'b10, data=4'b1011, defaults → cs and w_en high for 3 cycles, addr=2'b10, and preb_en high only for cycles 2–3. rsp_valid comes at T+3 with rsp_data=4'b0000.
- SEARCH with data=4'b0110 and sa_out forced to 4'b0100 during EVAL → w_en=MAC_en=0 and data=4'b0110. rsp_data=4'b0100.
- MAC_BAR addr=2'b01 → MAC_en=1 and read_bar=1 held through PRE and EVAL. MAC with PRE_CYCLES=2, EVAL_CYCLES=3 → rsp_valid at T+5.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid held high → rsp_data stays stable, cmd_ready=0, and the second command is accepted only after the response handshake plus 1 cycle.
- Input hold: change cmd_data/cmd_op during PRE → decoder outputs and the result reflect the original latched command.
